// File: rtl/alu_exec_unit.sv
// RV32I/RV64I integer execute unit with valid/ready handshakes and optional iterative shifter.
// Define ALU_MUL_EN to add an iterative shift-add MUL (R-type funct7=0x01, funct3=0).
module alu_exec_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_ITER = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      ctrl_ALU_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    localparam int unsigned SW = $clog2(XLEN);
    localparam int unsigned CW = SW + 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
    typedef enum logic [1:0] {IterSll, IterSrl, IterSra, IterMul} iter_e;

    state_e          state_q, state_d;
    iter_e           iter_q, iter_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            illegal_q, illegal_d;
    logic [CW-1:0]   cnt_q, cnt_d;
`ifdef ALU_MUL_EN
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
`endif

    logic            is_r, is_i, alt, mul_op;
    logic            dec_illegal, dec_iter;
    iter_e           dec_kind;
    logic [XLEN-1:0] dec_res;
    logic [SW-1:0]   shamt;

    always_comb begin
        is_r        = (ctrl_ALU_op == 3'b010);
        is_i        = (ctrl_ALU_op == 3'b001);
        alt         = (funct7 == 7'h20);
        shamt       = op_b[SW-1:0];
        mul_op      = 1'b0;
        dec_illegal = 1'b0;
        dec_iter    = 1'b0;
        dec_kind    = IterSll;
        dec_res     = '0;

        // I-type non-shift ops carry immediate bits in funct7, so it is ignored there
        if (!(is_r || is_i)) begin
            dec_illegal = 1'b1;
        end else if (is_i && funct3 != 3'd1 && funct3 != 3'd5) begin
            dec_illegal = 1'b0;
        end else if (funct7 == 7'h00) begin
            dec_illegal = 1'b0;
        end else if (alt) begin
            dec_illegal = is_r && funct3 != 3'd0 && funct3 != 3'd5;
`ifdef ALU_MUL_EN
        end else if (is_r && funct7 == 7'h01 && funct3 == 3'd0) begin
            mul_op = 1'b1;
`endif
        end else begin
            dec_illegal = 1'b1;
        end

        unique case (funct3)
            3'd0: dec_res = (is_r && alt) ? op_a - op_b : op_a + op_b;
            3'd1: dec_res = op_a << shamt;
            3'd2: dec_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            3'd3: dec_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            3'd4: dec_res = op_a ^ op_b;
            3'd5: dec_res = alt ? XLEN'($signed(op_a) >>> shamt) : op_a >> shamt;
            3'd6: dec_res = op_a | op_b;
            default: dec_res = op_a & op_b;
        endcase

        if (SHIFT_ITER != 0 && (funct3 == 3'd1 || funct3 == 3'd5) && shamt != '0) begin
            dec_iter = 1'b1;
            dec_kind = (funct3 == 3'd1) ? IterSll : (alt ? IterSra : IterSrl);
        end
        if (mul_op) begin
            dec_iter = 1'b1;
            dec_kind = IterMul;
        end
        if (dec_illegal) begin
            dec_res  = '0;
            dec_iter = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        res_d     = res_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
`ifdef ALU_MUL_EN
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    illegal_d = dec_illegal;
                    iter_d    = dec_kind;
                    if (!dec_iter) begin
                        res_d   = dec_res;
                        state_d = StDone;
                    end else begin
                        state_d = StBusy;
                        res_d   = op_a;
                        cnt_d   = {1'b0, shamt};
`ifdef ALU_MUL_EN
                        if (mul_op) begin
                            res_d    = '0;
                            cnt_d    = CW'(XLEN);
                            mcand_d  = op_a;
                            mplier_d = op_b;
                        end
`endif
                    end
                end
            end
            StBusy: begin
                unique case (iter_q)
                    IterSll: res_d = {res_q[XLEN-2:0], 1'b0};
                    IterSrl: res_d = {1'b0, res_q[XLEN-1:1]};
                    IterSra: res_d = {res_q[XLEN-1], res_q[XLEN-1:1]};
                    IterMul: begin
`ifdef ALU_MUL_EN
                        if (mplier_q[0]) begin
                            res_d = res_q + mcand_q;
                        end
                        mcand_d  = {mcand_q[XLEN-2:0], 1'b0};
                        mplier_d = {1'b0, mplier_q[XLEN-1:1]};
`endif
                    end
                    default: res_d = res_q;
                endcase
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            iter_q    <= IterSll;
            res_q     <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            res_q     <= res_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = res_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Drives a barrel-shifter and an iterative-shifter instance in lockstep and checks
// both against a behavioural RV ALU model, including latency and handshakes.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  ctrl_ALU_op = 3'b010;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;

    logic        bar_in_ready, bar_out_valid, bar_illegal;
    logic [31:0] bar_result;
    logic        it_in_ready, it_out_valid, it_illegal;
    logic [31:0] it_result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .SHIFT_ITER(0)) u_bar (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(bar_in_ready),
        .ctrl_ALU_op(ctrl_ALU_op), .funct3(funct3), .funct7(funct7),
        .op_a(op_a), .op_b(op_b), .out_valid(bar_out_valid), .out_ready(out_ready),
        .result(bar_result), .illegal(bar_illegal)
    );

    alu_exec_unit #(.XLEN(32), .SHIFT_ITER(1)) u_it (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(it_in_ready),
        .ctrl_ALU_op(ctrl_ALU_op), .funct3(funct3), .funct7(funct7),
        .op_a(op_a), .op_b(op_b), .out_valid(it_out_valid), .out_ready(out_ready),
        .result(it_result), .illegal(it_illegal)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: result, illegal flag, and edges from accept to out_valid for each variant
    task automatic model(input logic [2:0] c, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic ill,
                         output int lat_bar, output int lat_it);
        bit legal, mul;
        int s;
        logic [63:0] p;
        s = int'(b[4:0]);
        mul = 0;
        if (c == 3'b001) begin
            legal = (f3 inside {3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7}) || f7 == 7'h00 || f7 == 7'h20;
        end else if (c == 3'b010) begin
            legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
`ifdef ALU_MUL_EN
            if (f7 == 7'h01 && f3 == 3'd0) begin
                legal = 1;
                mul = 1;
            end
`endif
        end else begin
            legal = 0;
        end
        r = '0;
        ill = !legal;
        lat_bar = 0;
        lat_it = 0;
        if (legal && mul) begin
            p = {32'd0, a} * {32'd0, b};
            r = p[31:0];
            lat_bar = 32;
            lat_it = 32;
        end else if (legal) begin
            case (f3)
                3'd0: r = (c == 3'b010 && f7 == 7'h20) ? a - b : a + b;
                3'd1: r = a << s;
                3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: begin
                    r = a >> s;
                    if (f7 == 7'h20 && a[31]) r = r | ~(32'hFFFF_FFFF >> s);
                end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
            if (f3 == 3'd1 || f3 == 3'd5) lat_it = s;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] c, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [31:0] er;
        logic eill;
        int eb, ei, kb, ki;
        bit rdy_bad;
        model(c, f3, f7, a, b, er, eill, eb, ei);
        @(negedge clk);
        ctrl_ALU_op = c; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ctrl_ALU_op = 3'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
        op_a = $urandom; op_b = $urandom;
        kb = -1; ki = -1; rdy_bad = 0;
        for (int k = 0; k < 200; k++) begin
            if (bar_out_valid && kb < 0) kb = k;
            if (it_out_valid && ki < 0) ki = k;
            if (bar_in_ready || it_in_ready) rdy_bad = 1;
            if (kb >= 0 && ki >= 0) break;
            @(posedge clk);
            #1;
        end
        check({tag, "_lat_bar"}, 64'(kb), 64'(eb));
        check({tag, "_lat_it"}, 64'(ki), 64'(ei));
        check({tag, "_in_ready_low"}, 64'(rdy_bad), 64'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check({tag, "_held"}, {it_in_ready, bar_in_ready, it_out_valid, bar_out_valid,
                                   it_result, bar_result}, {4'b0011, er, er});
        end
        in_valid = 1'b0;
        check({tag, "_res_bar"}, {bar_illegal, bar_result}, {eill, er});
        check({tag, "_res_it"}, {it_illegal, it_result}, {eill, er});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drop"}, {bar_out_valid, it_out_valid, bar_in_ready, it_in_ready},
              64'b0011);
    endtask

    initial begin
        bit stale;
        logic [2:0] c;
        logic [6:0] f7;
        int pick;
        #12;
        check("reset_state_bar", {bar_out_valid, bar_illegal, bar_in_ready, bar_result},
              {3'b001, 32'd0});
        check("reset_state_it", {it_out_valid, it_illegal, it_in_ready, it_result},
              {3'b001, 32'd0});
        @(negedge clk);
        rst = 1'b0;

        run_op("sub", 3'b010, 3'd0, 7'h20, 32'd5, 32'd7, 0);
        run_op("slt", 3'b010, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("sltu", 3'b010, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("srai4", 3'b001, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 1);
        run_op("addi_bp", 3'b001, 3'd0, 7'h20, 32'd1, 32'd2, 3);
        run_op("ill_xor_alt", 3'b010, 3'd4, 7'h20, 32'h1234, 32'h5678, 0);
        run_op("ill_ctrl", 3'b011, 3'd0, 7'h00, 32'd1, 32'd1, 0);
        run_op("mul", 3'b010, 3'd0, 7'h01, 32'h0001_0000, 32'h0001_0001, 0);
        run_op("mul_f3", 3'b010, 3'd1, 7'h01, 32'd3, 32'd4, 0);
        run_op("sll0", 3'b010, 3'd1, 7'h00, 32'hDEAD_BEEF, 32'h20, 0);
        run_op("srl31", 3'b010, 3'd5, 7'h00, 32'hF000_0001, 32'd31, 0);
        run_op("slli_alt", 3'b001, 3'd1, 7'h20, 32'h0000_00FF, 32'd8, 0);

        for (int i = 0; i < 40; i++) begin
            pick = int'($urandom_range(0, 9));
            c = (pick < 5) ? 3'b010 : (pick < 9) ? 3'b001 : 3'($urandom);
            pick = int'($urandom_range(0, 5));
            f7 = (pick < 2) ? 7'h00 : (pick < 4) ? 7'h20 : (pick == 4) ? 7'h01 : 7'($urandom);
            run_op("rand", c, 3'($urandom), f7, $urandom, $urandom, int'($urandom_range(0, 2)));
        end

        // Reset during a long iterative shift must abort it without leaving a result behind
        @(negedge clk);
        ctrl_ALU_op = 3'b010; funct3 = 3'd1; funct7 = 7'h00; op_a = 32'd1; op_b = 32'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("busy_before_rst", {it_out_valid, it_in_ready}, 64'b00);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", {it_out_valid, it_in_ready, it_result}, {2'b01, 32'd0});
        check("rst_bar", {bar_out_valid, bar_in_ready, bar_result}, {2'b01, 32'd0});
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (it_out_valid || bar_out_valid) stale = 1;
        end
        check("no_stale_after_rst", 64'(stale), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised XLEN-wide RV32I/RV64I integer execute unit: decodes funct3/funct7/ctrl_ALU_op internally and computes the result.
- valid/ready handshakes on input and output; one operation in flight at a time.
- Shifts can run single-cycle or iterative (area mode); optional iterative MUL.
- Sits between the register-read stage and writeback.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- SHIFT_ITER, 0, 0 = single-cycle barrel shifter; 1 = iterative 1-bit-per-cycle shifter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit can accept an operation.
- ctrl_ALU_op  input  3  3'b010 R-type, 3'b001 I-type ALU; any other value is illegal.
- funct3  input  3  instruction funct3.
- funct7  input  7  instruction funct7. For I-type shifts this is imm[11:5].
- op_a  input  XLEN  rs1 value.
- op_b  input  XLEN  rs2 value or sign-extended immediate.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  computed value.
- illegal  output  1  qualifies result; set when the op was undecodable.

Behaviour:
- Reset (async, on rst rising or while high):
  - state=IDLE; out_valid=0, result=0, illegal=0, in_ready=1.
  - Reset mid-operation aborts it; no result is produced.
- Handshakes:
  - Accept on in_valid && in_ready.
  - in_ready = (state==IDLE) && !out_valid; no skid, one outstanding op.
  - Output transfer on out_valid && out_ready.
  - result and illegal are held stable while out_valid && !out_ready.
  - out_valid drops on the edge after the transfer; in_ready is high in the following cycle.
- Decode:
  - funct3 0: ADD. SUB only when R-type and funct7[5]=1.
  - funct3 1: SLL. 2: SLT (signed). 3: SLTU. 4: XOR.
  - funct3 5: SRL, or SRA when funct7[5]=1.
  - funct3 6: OR. 7: AND.
  - I-type funct3 0 ignores funct7.
- Illegal conditions:
  - funct7 not in {0x00, 0x20}, except I-type funct3 in {0,2,3,4,6,7}, where funct7 is ignored.
  - funct7=0x20 with R-type funct3 other than 0 or 5.
  - ctrl_ALU_op not 010 or 001.
  - Illegal op: one-cycle latency, result=0, illegal=1.
- Arithmetic:
  - Wrap-around modulo 2^XLEN; no overflow flag.
  - Shift amount s = op_b[log2(XLEN)-1:0].
  - SLT/SLTU produce 0 or 1, zero-extended.
- States:
  - IDLE: accept → DONE (1-cycle op) or BUSY (iterative op).
  - BUSY: internal counter; → DONE when the counter expires.
  - DONE: out_valid=1; on transfer → IDLE.
- Latency (accept edge = N):
  - 1-cycle ops: out_valid high after edge N.
  - SHIFT_ITER=1: shift of s performs one 1-bit shift per edge; out_valid high after edge N+s.
  - s=0 behaves as a 1-cycle op.
  - SRA iterative fill replicates the sign bit each step.
- Simultaneous events:
  - in_valid is ignored while busy or holding.
  - Input fields are captured at accept; later changes have no effect.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined:
  - R-type funct7=0x01, funct3=0 performs MUL: low XLEN bits of op_a*op_b.
  - Iterative shift-add, one multiplier bit per cycle, in state BUSY.
  - out_valid high after edge N+XLEN.
  - funct7=0x01 with funct3≠0 is illegal.
- Undefined:
  - funct7=0x01 is always illegal.
  - No multiplier logic is synthesised.

Test Plan:
- Reset: assert rst mid-BUSY of SLL by 20 (SHIFT_ITER=1) → out_valid=0, result=0, in_ready=1 immediately; no stale result after deassert.
- R-type SUB: funct3=0, funct7=0x20, a=5, b=7, XLEN=32 → result=0xFFFFFFFE after 1 cycle, illegal=0.
- Signed compare: SLT a=0xFFFFFFFF, b=1 → 1; SLTU with the same operands → 0.
- SHIFT_ITER=1 SRAI: funct7=0x20, a=0x80000000, s=4 → result=0xF8000000 exactly 4 cycles after accept.
  - in_ready low throughout BUSY and DONE.
- Backpressure: ADDI a=1, b=2 with out_ready=0 for 3 cycles → result=3 held stable, second in_valid ignored until transfer.
- Illegal: R-type funct3=4, funct7=0x20 → illegal=1, result=0.
  - With ALU_MUL_EN, MUL a=0x10000, b=0x10001 → 0x00010000 after 32 cycles.
